vector_checker16: RTL and testbench

Hardware response checker for gate-level chip benches. It is the consuming end of the stimulus/response flow: expected 16-bit results are preloaded into a small vector memory, then observed DUT outputs are streamed in over a valid/ready handshake. Each observed word is compared in order, mismatches are counted, and the first failing index is recorded. Pass/fail is reported at the end of a run. It sits beside a DUT such as a 16-bit bitwise gate and replaces manual inspection of the printed truth table.

---
 rtl/vector_checker16.sv | 131 +++++++++++++
 tb/tb_vector_checker16.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_checker16.sv
// ============================================================================
// Module   : vector_checker16
// Purpose  : In-order response checker; compares streamed words against
//            preloaded expected vectors and reports errors and pass/fail.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vector_checker16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW:0]      count,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_data,
  output logic             obs_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [AW:0]      err_count,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW:0] c_depth = DEPTH[AW:0];

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_idx;
  logic [AW:0]      r_n;

  logic [AW:0]      w_n;
  logic             w_accept;
  logic             w_diff;
  logic             w_last;
  logic [AW:0]      w_err_next;

  assign w_n        = (count > c_depth) ? c_depth : count;
  assign w_accept   = (r_state == S_RUN) && obs_valid && obs_ready;
  assign w_diff     = (obs_data != r_mem[r_idx]);
  assign w_last     = ({1'b0, r_idx} == (r_n - 1'b1));
  assign w_err_next = err_count + {{AW{1'b0}}, w_diff};

  // Expected vectors are frozen while a run is consuming them.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && (r_state != S_RUN)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_n             <= '0;
      obs_ready       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch        <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_n             <= w_n;
            r_idx           <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            if (w_n == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              r_state   <= S_RUN;
              busy      <= 1'b1;
              obs_ready <= 1'b1;
              done      <= 1'b0;
              pass      <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_idx <= r_idx + 1'b1;
            if (w_diff) begin
              mismatch  <= 1'b1;
              err_count <= w_err_next;
              if (!first_err_valid) begin
                first_err_idx   <= r_idx;
                first_err_valid <= 1'b1;
              end
            end
            // Pass must include the verdict of the word accepted this cycle.
            if (w_last) begin
              r_state   <= S_DONE;
              obs_ready <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (w_err_next == '0);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_checker16.sv
// ============================================================================
// Module   : tb_vector_checker16
// Purpose  : Scoreboard bench for vector_checker16.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vector_checker16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [3:0]  count;
  logic        obs_valid;
  logic [15:0] obs_data;
  logic        obs_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        mismatch;
  logic [3:0]  err_count;
  logic [2:0]  first_err_idx;
  logic        first_err_valid;

  vector_checker16 dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .count(count), .obs_valid(obs_valid), .obs_data(obs_data),
    .obs_ready(obs_ready), .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_mem [8];
  logic [15:0] obs_vec [8];
  logic        mm_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_and16();
    mem_write(3'd0, 16'h0000);
    mem_write(3'd1, 16'h0000);
    mem_write(3'd2, 16'hFFFF);
    mem_write(3'd3, 16'h0000);
    mem_write(3'd4, 16'h0CC0);
    mem_write(3'd5, 16'h1034);
    for (int i = 0; i < 8; i++) obs_vec[i] = model_mem[i];
  endtask

  task automatic start_run(input logic [3:0] c, input bit expect_run);
    @(negedge clk);
    start = 1'b1; count = c;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, expect_run);
    check("start_ready", obs_ready, expect_run);
    check("start_done", done, !expect_run);
    check("start_errcnt", err_count, 0);
    check("start_fvalid", first_err_valid, 0);
  endtask

  // Streams obs_vec[0..stop-1]; gap=1 drives valid as 1,0,0,1,0,0...
  task automatic stream(input int n, input bit gap, input int stop);
    int acc = 0;
    int cyc = 0;
    bit pend = 1'b0;
    bit v;
    while (acc < stop && cyc < 200) begin
      @(negedge clk);
      obs_valid = 1'b0;
      if (pend) begin
        check("mismatch_pulse", mismatch, mm_q.pop_front());
        pend = 1'b0;
      end else begin
        check("mismatch_quiet", mismatch, 0);
      end
      check("run_done_low", done, 0);
      check("run_ready", obs_ready, 1);
      v = gap ? ((cyc % 3) == 0) : 1'b1;
      obs_valid = v;
      obs_data  = obs_vec[acc];
      if (v && obs_ready) begin
        mm_q.push_back(obs_vec[acc] != model_mem[acc]);
        acc++;
        pend = 1'b1;
      end
      cyc++;
    end
    if (cyc >= 200) check("stream_timeout", cyc, 0);
    @(negedge clk);
    obs_valid = 1'b0;
    if (pend) check("mismatch_pulse", mismatch, mm_q.pop_front());
    if (stop == n) begin
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_ready", obs_ready, 0);
      @(negedge clk);
      check("end_mismatch_clear", mismatch, 0);
    end
  endtask

  task automatic check_results(input int n);
    int errs = 0;
    int fi = 0;
    bit fv = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (obs_vec[i] != model_mem[i]) begin
        if (!fv) begin fi = i; fv = 1'b1; end
        errs++;
      end
    end
    check("res_done", done, 1);
    check("res_pass", pass, errs == 0);
    check("res_errcnt", err_count, errs);
    check("res_fvalid", first_err_valid, fv);
    if (fv) check("res_fidx", first_err_idx, fi);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; count = '0; obs_valid = 1'b0; obs_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", obs_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_errcnt", err_count, 0);
    check("rst_fvalid", first_err_valid, 0);
    reset = 1'b0;

    // Clean run
    load_and16();
    start_run(4'd6, 1'b1);
    stream(6, 1'b0, 6);
    check_results(6);

    // Two corruptions
    obs_vec[2] = 16'h1234;
    obs_vec[5] = 16'hFFFF;
    start_run(4'd6, 1'b1);
    stream(6, 1'b0, 6);
    check_results(6);
    check("two_err_count", err_count, 2);
    check("two_err_fidx", first_err_idx, 2);

    // Gapped valid, same corrupted data
    start_run(4'd6, 1'b1);
    stream(6, 1'b1, 6);
    check_results(6);

    // Zero-length run
    start_run(4'd0, 1'b0);
    check("zero_pass", pass, 1);
    @(negedge clk);
    check("zero_ready_hold", obs_ready, 0);

    // Count beyond depth clamps to 8
    mem_write(3'd6, 16'hA5A5);
    mem_write(3'd7, 16'h5A5A);
    for (int i = 0; i < 8; i++) obs_vec[i] = model_mem[i];
    obs_vec[7] = 16'h5A5B;
    start_run(4'd12, 1'b1);
    stream(8, 1'b0, 8);
    check_results(8);
    check("clamp_fidx", first_err_idx, 7);

    // Reset mid-run after 3 accepts with one mismatch
    for (int i = 0; i < 8; i++) obs_vec[i] = model_mem[i];
    obs_vec[1] = 16'hDEAD;
    start_run(4'd6, 1'b1);
    stream(6, 1'b0, 3);
    check("pre_rst_errcnt", err_count, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", obs_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_mismatch", mismatch, 0);
    check("mid_rst_errcnt", err_count, 0);
    check("mid_rst_fidx", first_err_idx, 0);
    check("mid_rst_fvalid", first_err_valid, 0);
    obs_vec[1] = model_mem[1];
    start_run(4'd6, 1'b1);
    stream(6, 1'b0, 6);
    check_results(6);

    // Write and start during RUN are ignored
    obs_vec[3] = 16'h0001;
    start_run(4'd6, 1'b1);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF; start = 1'b1; count = 4'd2;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    check("run_write_busy", busy, 1);
    stream(6, 1'b0, 6);
    check_results(6);

    // Rewrite after DONE and restart uses new value; results clear
    mem_write(3'd0, 16'hBEEF);
    check("done_hold_errcnt", err_count, 1);
    for (int i = 0; i < 8; i++) obs_vec[i] = model_mem[i];
    start_run(4'd6, 1'b1);
    stream(6, 1'b0, 6);
    check_results(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
